data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

- Bridges the core's single-cycle data-memory port to a handshaked external memory/peripheral bus.
- Detects each core data access, launches it on the external request channel, and freezes the core by deasserting its clock enable until the response arrives or a timeout expires.
- Returns read data on the core's `data_in` path and holds it stable for the writeback stage.
- Sits between the core's data-memory outputs (address, mask, mode, lock, write data) and the system interconnect.

## Interface

- `TIMEOUT_CYCLES`, default 255: maximum wait for `ext_rsp_valid` after the request handshake; range 1..65535.
- `ERR_RDATA`, default 32'hFFFF_FFFF: read data returned when an access times out.

- `clk` in 1: single clock for all logic.
- `async_rst` in 1: reset, asynchronous and active-high.
- `core_address` in 30: word address from the core.
- `core_mask` in 4: byte enables; any nonzero value marks an access.
- `core_mode` in 1: 1 = write, 0 = read.
- `core_lock` in 1: bus lock request from the core.
- `core_wdata` in 32: write data, little-endian, passed through unchanged.
- `core_rdata` out 32: read data to the core's `data_in`.
- `core_clk_en` out 1: clock enable to the core.
- `ext_req_valid` out 1: request valid on the external bus.
- `ext_req_ready` in 1: external bus accepts the request.
- `ext_addr` out 30: external address.
- `ext_mask` out 4: external byte enables.
- `ext_we` out 1: external write enable.
- `ext_wdata` out 32: external write data.
- `ext_lock` out 1: external bus lock.
- `ext_rsp_valid` in 1: one-cycle response strobe (read data or write ack).
- `ext_rsp_data` in 32: response data; sampled only on reads.
- `err_pulse` out 1: one-cycle pulse when an access times out.
- `err_count` out 8: saturating count of timeouts.

## Operation

- States: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `core_mask != 0`, latch address, mask, mode and wdata, drop `core_clk_en` combinationally in that same cycle, and go to REQ.
  - Otherwise hold `core_clk_en = 1`.
- **REQ**
  - Assert `ext_req_valid` with the latched fields.
  - On `ext_req_ready`, go to WAIT.
  - Latched fields stay stable while valid and not ready.
- **WAIT**
  - On `ext_rsp_valid`, go to DONE. For a read, capture `ext_rsp_data` into `core_rdata`.
  - The timeout counter counts WAIT cycles. When it reaches `TIMEOUT_CYCLES` without a response, go to DONE, load `ERR_RDATA` for a read, pulse `err_pulse`, and increment `err_count`, saturating at 255.
- **DONE**
  - `core_clk_en = 1` for exactly one cycle, then go to IDLE.
  - The access still presented by the core during DONE is not relaunched.
- `core_clk_en` is 0 in REQ and WAIT.
- `core_rdata` holds its value until the next read completion. Writes never modify it.
- `ext_lock` is registered from `core_lock`.
  - Set when `core_lock` is seen in any state.
  - Cleared only in IDLE when `core_lock = 0`, so a lock never drops mid-access.
- An `ext_rsp_valid` arriving in IDLE, REQ or DONE is ignored: stale or spurious.
- A response in the same cycle the timeout expires counts as success, with no error.

## Timing

- **Reset values:** state IDLE, `core_rdata` 0, `ext_req_valid` 0, `ext_lock` 0, `err_pulse` 0, `err_count` 0, latched fields 0, `core_clk_en` 1 while the mask is 0.
- **Minimum access latency:** 3 stalled-edge-free cycles from access detect to core advance, i.e. IDLE→REQ (ready=1)→WAIT (rsp=1)→DONE.
- `ext_req_valid` rises the cycle after detection and falls on the cycle after the handshake.
- Timeout fires on the `TIMEOUT_CYCLES`-th WAIT cycle.
- **Async reset mid-access:** immediately returns to IDLE with all outputs at reset values. The external bus must tolerate the abandoned request.
- Back-to-back accesses are allowed: DONE→IDLE→detect next access in the following cycle.

## Structure

- **Package `srv1_bus_pkg`:**
  - State enum `bus_state_t` (IDLE, REQ, WAIT, DONE).
  - Constants `MODE_READ = 0`, `MODE_WRITE = 1`.
  - Error counter width.
- **Sub-module `bus_timeout_ctr`:** 16-bit counter with clear, enable, and a terminal-count output compared against `TIMEOUT_CYCLES`.

## Test plan

- Read at address 0x0000_0010, `ext_req_ready` = 1, response 0xDEAD_BEEF after 2 wait cycles.
  - `core_clk_en` is low 4 cycles.
  - `core_rdata` = 0xDEAD_BEEF from DONE onward.
  - One `ext_req_valid` pulse.
- Write of 0x1234_5678 with mask 4'b0011, ready held low 3 cycles.
  - `ext_req_valid` is held 4 cycles with stable addr, mask and data.
  - `core_rdata` is unchanged.
- Read with no response and `TIMEOUT_CYCLES` = 4.
  - `core_rdata` = 0xFFFF_FFFF.
  - `err_pulse` is high 1 cycle and `err_count` = 1.
  - 300 repeated timeouts saturate `err_count` at 255.
- Locked sequence: `core_lock` = 1 across two accesses, then dropped.
  - `ext_lock` stays 1 through both accesses and the intervening IDLE.
  - `ext_lock` clears one cycle after `core_lock` = 0 in IDLE.
- `async_rst` asserted during WAIT.
  - Outputs go to reset values immediately.
  - A later `ext_rsp_valid` in IDLE leaves `core_rdata` = 0.
- Response and timeout expiry in the same cycle: data is accepted, `err_pulse` stays 0, and `err_count` is unchanged.

Source files
------------

// File: rtl/srv1_bus_pkg.sv
// Shared types and constants for the core data-bus responder.
package srv1_bus_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bus_state_t;

  // Encoding of core_mode.
  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Timeout error counter width and its saturation value.
  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Width of the response timeout counter.
  localparam int TMO_CTR_W = 16;

  // Increment that sticks at the maximum instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (v == ERR_CNT_MAX) begin
      return v;
    end
    return v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Response timeout counter: counts enabled cycles since the last clear and
// flags the cycle that is the TIMEOUT_CYCLES-th enabled cycle.
module bus_timeout_ctr
  import srv1_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = TMO_CTR_W;
  localparam logic [W:0] TC_VAL = (W+1)'(TIMEOUT_CYCLES);

  logic [W-1:0] r_count;
  logic [W:0]   w_count_plus1;

  // r_count holds the number of enabled cycles already completed, so the
  // current enabled cycle is number r_count + 1.
  assign w_count_plus1 = {1'b0, r_count} + {{W{1'b0}}, 1'b1};
  assign o_tc          = i_en && (w_count_plus1 == TC_VAL);

  // Count enabled cycles; clear dominates, and the count sticks at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= w_count_plus1[W-1:0];
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// Bridges the core's single-cycle data-memory port to a valid/ready external
// bus. Each access stalls the core (core_clk_en low) until the external
// response arrives or the response timeout expires.
//
// Handshake: a request transfers on a cycle where ext_req_valid and
// ext_req_ready are both high; while valid is high and ready is low the
// request fields stay stable and valid is not withdrawn. ext_rsp_valid is a
// single-cycle strobe with no back-pressure, only honoured in WAIT.
module data_bus_responder
  import srv1_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        async_rst,
  input  logic [29:0] core_address,
  input  logic [3:0]  core_mask,
  input  logic        core_mode,
  input  logic        core_lock,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_clk_en,
  output logic        ext_req_valid,
  input  logic        ext_req_ready,
  output logic [29:0] ext_addr,
  output logic [3:0]  ext_mask,
  output logic        ext_we,
  output logic [31:0] ext_wdata,
  output logic        ext_lock,
  input  logic        ext_rsp_valid,
  input  logic [31:0] ext_rsp_data,
  output logic        err_pulse,
  output logic [7:0]  err_count,
  output bus_state_t  o_dbg_state
);

  bus_state_t r_state;
  bus_state_t w_next_state;

  logic [29:0] r_addr;
  logic [3:0]  r_mask;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_lock;
  logic        r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic w_clk_en;
  logic w_latch;
  logic w_rsp_ok;
  logic w_timeout;
  logic w_tmo_clr;
  logic w_tmo_en;
  logic w_tmo_tc;

  // The timer only runs in WAIT and restarts from zero on every entry.
  assign w_tmo_en  = (r_state == WAIT);
  assign w_tmo_clr = (r_state != WAIT);

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk (clk),
    .i_rst (async_rst),
    .i_clr (w_tmo_clr),
    .i_en  (w_tmo_en),
    .o_tc  (w_tmo_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and per-state strobes. The core is released only in
  // DONE, and in IDLE while no access is presented; the access still shown
  // by the core during DONE is deliberately not relaunched.
  always_comb begin
    w_next_state = r_state;
    w_clk_en     = 1'b0;
    w_latch      = 1'b0;
    w_rsp_ok     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (core_mask != 4'b0000) begin
          w_latch      = 1'b1;
          w_next_state = REQ;
        end else begin
          w_clk_en = 1'b1;
        end
      end
      REQ: begin
        if (ext_req_ready) begin
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        // A response in the expiry cycle wins over the timeout.
        if (ext_rsp_valid) begin
          w_rsp_ok     = 1'b1;
          w_next_state = DONE;
        end else if (w_tmo_tc) begin
          w_timeout    = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_clk_en     = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Capture the core's access fields at detection; held until the next one.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_addr  <= '0;
      r_mask  <= '0;
      r_we    <= MODE_READ;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_addr  <= core_address;
      r_mask  <= core_mask;
      r_we    <= core_mode;
      r_wdata <= core_wdata;
    end
  end

  // Read data to the core: updated only when a read completes.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_rdata <= '0;
    end else if (r_we == MODE_READ) begin
      if (w_rsp_ok) begin
        r_rdata <= ext_rsp_data;
      end else if (w_timeout) begin
        r_rdata <= ERR_RDATA;
      end
    end
  end

  // Timeout reporting: one-cycle pulse (seen in DONE) and saturating count.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_timeout;
      if (w_timeout) begin
        r_err_count <= sat_inc(r_err_count);
      end
    end
  end

  // Bus lock: set whenever the core asks, released only from IDLE so an
  // access in flight never loses its lock.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_lock <= 1'b0;
    end else if (core_lock) begin
      r_lock <= 1'b1;
    end else if (r_state == IDLE) begin
      r_lock <= 1'b0;
    end
  end

  assign core_clk_en   = w_clk_en;
  assign core_rdata    = r_rdata;
  assign ext_req_valid = (r_state == REQ);
  assign ext_addr      = r_addr;
  assign ext_mask      = r_mask;
  assign ext_we        = r_we;
  assign ext_wdata     = r_wdata;
  assign ext_lock      = r_lock;
  assign err_pulse     = r_err_pulse;
  assign err_count     = r_err_count;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;
  import srv1_bus_pkg::*;

  localparam int          TMO     = 4;
  localparam logic [31:0] ERR_VAL = 32'hFFFF_FFFF;

  logic        clk;
  logic        async_rst;
  logic [29:0] core_address;
  logic [3:0]  core_mask;
  logic        core_mode;
  logic        core_lock;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_clk_en;
  logic        ext_req_valid;
  logic        ext_req_ready;
  logic [29:0] ext_addr;
  logic [3:0]  ext_mask;
  logic        ext_we;
  logic [31:0] ext_wdata;
  logic        ext_lock;
  logic        ext_rsp_valid;
  logic [31:0] ext_rsp_data;
  logic        err_pulse;
  logic [7:0]  err_count;
  bus_state_t  dbg_state;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected core_rdata after each access completes.
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata;
  int          model_err;

  data_bus_responder #(
    .TIMEOUT_CYCLES(TMO),
    .ERR_RDATA     (ERR_VAL)
  ) dut (
    .clk          (clk),
    .async_rst    (async_rst),
    .core_address (core_address),
    .core_mask    (core_mask),
    .core_mode    (core_mode),
    .core_lock    (core_lock),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata),
    .core_clk_en  (core_clk_en),
    .ext_req_valid(ext_req_valid),
    .ext_req_ready(ext_req_ready),
    .ext_addr     (ext_addr),
    .ext_mask     (ext_mask),
    .ext_we       (ext_we),
    .ext_wdata    (ext_wdata),
    .ext_lock     (ext_lock),
    .ext_rsp_valid(ext_rsp_valid),
    .ext_rsp_data (ext_rsp_data),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .o_dbg_state  (dbg_state)
  );

  // Clock and global watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One complete core access. rsp_at = WAIT cycle carrying the response
  // (0 = never). Returns positioned in the IDLE cycle after DONE + 1.
  task automatic access(input logic [29:0] addr, input logic [3:0] mask,
                        input logic we, input logic [31:0] wdata,
                        input int ready_delay, input int rsp_at,
                        input logic [31:0] rsp_data, input logic chk_lock);
    int low_cnt;
    int vld_cnt;
    int wait_n;
    logic timed_out;
    logic [31:0] exp_rd;
    logic [31:0] got;
    timed_out = (rsp_at == 0) || (rsp_at > TMO);
    wait_n    = timed_out ? TMO : rsp_at;
    if (we) exp_rd = model_rdata;
    else if (timed_out) exp_rd = ERR_VAL;
    else exp_rd = rsp_data;
    model_rdata = exp_rd;
    exp_q.push_back(exp_rd);
    low_cnt = 0;
    vld_cnt = 0;

    // Detect cycle (IDLE with mask set).
    core_address  = addr;
    core_mask     = mask;
    core_mode     = we;
    core_wdata    = wdata;
    ext_req_ready = 1'b0;
    ext_rsp_valid = 1'b0;
    #1;
    if (core_clk_en === 1'b0) low_cnt++;
    check("detect_clk_en", core_clk_en, 1'b0);
    check("detect_req_valid", ext_req_valid, 1'b0);
    tick();

    // Request phase.
    for (int i = 0; i <= ready_delay; i++) begin
      ext_req_ready = (i == ready_delay);
      #1;
      if (core_clk_en === 1'b0) low_cnt++;
      if (ext_req_valid === 1'b1) vld_cnt++;
      check("req_addr", ext_addr, addr);
      check("req_mask", ext_mask, mask);
      check("req_we", ext_we, we);
      check("req_wdata", ext_wdata, wdata);
      if (chk_lock) check("req_lock", ext_lock, 1'b1);
      tick();
    end
    ext_req_ready = 1'b0;

    // Wait phase.
    for (int i = 1; i <= wait_n; i++) begin
      ext_rsp_valid = (i == rsp_at);
      ext_rsp_data  = (i == rsp_at) ? rsp_data : $urandom;
      #1;
      if (core_clk_en === 1'b0) low_cnt++;
      if (ext_req_valid === 1'b1) vld_cnt++;
      check("wait_err_pulse", err_pulse, 1'b0);
      if (chk_lock) check("wait_lock", ext_lock, 1'b1);
      tick();
    end
    ext_rsp_valid = 1'b0;

    // DONE: core released, result visible.
    #1;
    check("done_clk_en", core_clk_en, 1'b1);
    check("done_req_valid", ext_req_valid, 1'b0);
    check("done_err_pulse", err_pulse, timed_out);
    if (timed_out && model_err < 255) model_err++;
    check("done_err_count", err_count, 32'(model_err));
    if (chk_lock) check("done_lock", ext_lock, 1'b1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check("rdata", core_rdata, got);
    end
    tick();

    // Back in IDLE; core moved on to a non-memory instruction.
    core_mask = 4'b0000;
    #1;
    check("idle_clk_en", core_clk_en, 1'b1);
    check("idle_err_pulse", err_pulse, 1'b0);
    check("idle_req_valid", ext_req_valid, 1'b0);
    check("idle_rdata", core_rdata, model_rdata);
    if (chk_lock) check("idle_lock", ext_lock, 1'b1);
    check("stall_cycles", 32'(low_cnt), 32'(1 + ready_delay + 1 + wait_n));
    check("valid_cycles", 32'(vld_cnt), 32'(ready_delay + 1));
    tick();
  endtask

  initial begin
    async_rst     = 1'b1;
    core_address  = '0;
    core_mask     = '0;
    core_mode     = MODE_READ;
    core_lock     = 1'b0;
    core_wdata    = '0;
    ext_req_ready = 1'b0;
    ext_rsp_valid = 1'b0;
    ext_rsp_data  = '0;
    model_rdata   = '0;
    model_err     = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("rst_rdata", core_rdata, 32'd0);
    check("rst_req_valid", ext_req_valid, 1'b0);
    check("rst_lock", ext_lock, 1'b0);
    check("rst_err_pulse", err_pulse, 1'b0);
    check("rst_err_count", err_count, 8'd0);
    check("rst_addr", ext_addr, 30'd0);
    check("rst_clk_en", core_clk_en, 1'b1);
    async_rst = 1'b0;
    tick();

    // Read, ready immediately, response in 2nd WAIT cycle.
    access(30'h10, 4'hF, MODE_READ, 32'h0, 0, 2, 32'hDEAD_BEEF, 1'b0);

    // Write with ready held low 3 cycles; rdata must stay DEADBEEF.
    access(30'h2A5, 4'b0011, MODE_WRITE, 32'h1234_5678, 3, 1, 32'h5555_AAAA, 1'b0);

    // Read that times out.
    access(30'h123, 4'hF, MODE_READ, 32'h0, 1, 0, 32'h0, 1'b0);

    // Response in the expiry cycle counts as success.
    access(30'h124, 4'b1000, MODE_READ, 32'h0, 0, TMO, 32'hA5A5_0F0F, 1'b0);

    // Locked pair of accesses, then release in IDLE.
    core_lock = 1'b1;
    #1;
    tick();
    #1;
    check("lock_set", ext_lock, 1'b1);
    access(30'h300, 4'hF, MODE_READ, 32'h0, 1, 1, 32'h0BAD_F00D, 1'b1);
    access(30'h301, 4'hF, MODE_WRITE, 32'hFACE_CAFE, 0, 3, 32'h0, 1'b1);
    #1;
    check("lock_idle_hold", ext_lock, 1'b1);
    core_lock = 1'b0;
    #1;
    check("lock_before_clear", ext_lock, 1'b1);
    tick();
    #1;
    check("lock_cleared", ext_lock, 1'b0);
    tick();

    // Repeated timeouts saturate the error counter.
    for (int n = 0; n < 300; n++) begin
      access(30'($urandom), 4'($urandom_range(1, 15)), MODE_READ, 32'h0,
             $urandom_range(0, 2), 0, 32'h0, 1'b0);
    end
    #1;
    check("err_saturated", err_count, 8'd255);
    tick();

    // Asynchronous reset in the middle of WAIT.
    core_address = 30'h77;
    core_mask    = 4'hF;
    core_mode    = MODE_READ;
    #1;
    tick();
    ext_req_ready = 1'b1;
    #1;
    tick();
    ext_req_ready = 1'b0;
    #1;
    check("pre_rst_clk_en", core_clk_en, 1'b0);
    async_rst = 1'b1;
    #1;
    check("arst_rdata", core_rdata, 32'd0);
    check("arst_req_valid", ext_req_valid, 1'b0);
    check("arst_err_count", err_count, 8'd0);
    check("arst_addr", ext_addr, 30'd0);
    check("arst_clk_en_masked", core_clk_en, 1'b0);
    core_mask = 4'b0000;
    #1;
    check("arst_clk_en", core_clk_en, 1'b1);
    async_rst   = 1'b0;
    model_rdata = '0;
    model_err   = 0;
    exp_q.delete();
    tick();
    ext_rsp_valid = 1'b1;
    ext_rsp_data  = 32'hCAFE_BABE;
    #1;
    tick();
    ext_rsp_valid = 1'b0;
    #1;
    check("stray_rsp_rdata", core_rdata, 32'd0);
    tick();

    // Still functional after reset.
    access(30'h3F_FFFF, 4'b0100, MODE_READ, 32'h0, 2, 1, 32'h1357_9BDF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
